// File: rtl/icap_stream_pkg.sv
// icap_stream_pkg: shared state encoding, error codes and bit-order helper
// for the ICAPE3 bitstream streaming controller.
package icap_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PRERROR = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_TKEEP   = 3'd3;
    localparam logic [2:0] ERR_ABORT   = 3'd4;

    localparam logic [7:0] KEEP_FULL = 8'hFF;
    localparam logic [7:0] KEEP_LOW  = 8'h0F;

    // Reverse the bit order inside each byte, keeping byte positions.
    function automatic logic [31:0] bit_reverse_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = w[8*b+7-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_stream_controller_timeout.sv
// icap_timeout_counter: cycle counter with synchronous clear and enable;
// flags expiry in the cycle the enabled count reaches LIMIT.
module icap_timeout_counter #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Expiry is seen in the LIMIT-th enabled cycle since the last clear.
    always_comb begin
        expired = en && (cnt_q == W'(LIMIT - 1));
    end

    // Next count: clear wins, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/icap_stream_controller.sv
// icap_stream_controller: feeds 64-bit AXI-Stream bitstream beats into ICAPE3
// as 32-bit words and tracks PR completion, errors and word count.
module icap_stream_controller
    import icap_stream_pkg::*;
#(
    parameter bit          BIT_SWAP       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter bit          REQUIRE_PRDONE = 1'b1
) (
    input  logic        AxiBusClock,
    input  logic        xAxiBusReset_n,
    input  logic        xStart,
    input  logic        xAbort,
    input  logic [63:0] xIcapS_AXI_tdata,
    input  logic [7:0]  xIcapS_AXI_tkeep,
    input  logic        xIcapS_AXI_tlast,
    input  logic        xIcapS_AXI_tvalid,
    output logic        xIcapS_AXI_tready,
    input  logic        xIcapAvail,
    input  logic        xIcapPrDone,
    input  logic        xIcapPrError,
    output logic        xIcapCsib,
    output logic        xIcapRdWrB,
    output logic [31:0] xIcapData,
    output logic        xBusy,
    output logic        xDone,
    output logic        xError,
    output logic [2:0]  xErrorCode,
    output logic [31:0] xWordCount
);

    state_t      state_q, state_d;
    logic        tready_q, tready_d;
    logic        buf_valid_q, buf_valid_d;
    logic [63:0] buf_data_q, buf_data_d;
    logic        buf_has_hi_q, buf_has_hi_d;
    logic        buf_last_q, buf_last_d;
    logic        half_q, half_d;
    logic        last_seen_q, last_seen_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [31:0] word_cnt_q, word_cnt_d;

    logic        hs;
    logic        keep_ok;
    logic        last_now;
    logic        emit;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_expired;
    logic [2:0]  err_now;
    logic [31:0] cur_word;
    logic [31:0] out_word;

    // Beat handshake, tkeep legality and the word currently offered to ICAP.
    always_comb begin
        hs       = xIcapS_AXI_tvalid && tready_q;
        keep_ok  = (xIcapS_AXI_tkeep == KEEP_FULL) ||
                   ((xIcapS_AXI_tkeep == KEEP_LOW) && xIcapS_AXI_tlast);
        last_now = last_seen_q || (hs && xIcapS_AXI_tlast);
        cur_word = half_q ? buf_data_q[63:32] : buf_data_q[31:0];
        out_word = BIT_SWAP ? bit_reverse_bytes(cur_word) : cur_word;
    end

    // Error detection while a transfer is active; lower code wins a tie.
    always_comb begin
        err_now = ERR_NONE;
        if ((state_q == ST_STREAM) || (state_q == ST_WAIT_DONE)) begin
            if (xIcapPrError) begin
                err_now = ERR_PRERROR;
            end else if (tmr_expired) begin
                err_now = ERR_TIMEOUT;
            end else if ((state_q == ST_STREAM) && hs && !keep_ok) begin
                err_now = ERR_TKEEP;
            end else if (xAbort) begin
                err_now = ERR_ABORT;
            end
        end
    end

    // A word is written only when AVAIL is high and no error fires this cycle,
    // so CSIB and I follow AVAIL in the same cycle with no lag.
    always_comb begin
        emit    = (state_q == ST_STREAM) && buf_valid_q && xIcapAvail &&
                  (err_now == ERR_NONE);
        tmr_clr = (state_q == ST_IDLE) || emit;
        tmr_en  = ((state_q == ST_STREAM) && buf_valid_q && !xIcapAvail) ||
                  (state_q == ST_WAIT_DONE);
    end

    icap_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (AxiBusClock),
        .rst_n   (xAxiBusReset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_has_hi_d = buf_has_hi_q;
        buf_last_d   = buf_last_q;
        half_d       = half_q;
        last_seen_d  = last_seen_q;
        data_d       = data_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        word_cnt_d   = word_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (xStart) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    word_cnt_d  = '0;
                    buf_valid_d = 1'b0;
                    half_d      = 1'b0;
                    last_seen_d = 1'b0;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (err_now != ERR_NONE) begin
                    error_d     = 1'b1;
                    err_code_d  = error_q ? err_code_q : err_now;
                    buf_valid_d = 1'b0;
                    half_d      = 1'b0;
                    last_seen_d = last_now;
                    state_d     = last_now ? ST_IDLE : ST_DRAIN;
                end else if (emit) begin
                    data_d     = out_word;
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (!half_q && buf_has_hi_q) begin
                        half_d = 1'b1;
                    end else begin
                        buf_valid_d = 1'b0;
                        half_d      = 1'b0;
                        if (buf_last_q) begin
                            if (REQUIRE_PRDONE) begin
                                state_d = ST_WAIT_DONE;
                            end else begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end else if (hs) begin
                    buf_data_d   = xIcapS_AXI_tdata;
                    buf_has_hi_d = (xIcapS_AXI_tkeep[7:4] == 4'hF);
                    buf_last_d   = xIcapS_AXI_tlast;
                    buf_valid_d  = 1'b1;
                    half_d       = 1'b0;
                    last_seen_d  = last_now;
                end
            end
            ST_WAIT_DONE: begin
                if (err_now != ERR_NONE) begin
                    error_d    = 1'b1;
                    err_code_d = error_q ? err_code_q : err_now;
                    state_d    = ST_IDLE;
                end else if (xIcapPrDone) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (hs && xIcapS_AXI_tlast) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        tready_d = ((state_d == ST_STREAM) && !buf_valid_d) ||
                   (state_d == ST_DRAIN);
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            state_q      <= ST_IDLE;
            tready_q     <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            buf_has_hi_q <= 1'b0;
            buf_last_q   <= 1'b0;
            half_q       <= 1'b0;
            last_seen_q  <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            buf_has_hi_q <= buf_has_hi_d;
            buf_last_q   <= buf_last_d;
            half_q       <= half_d;
            last_seen_q  <= last_seen_d;
            data_q       <= data_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign xIcapS_AXI_tready = tready_q;
    assign xIcapCsib         = !emit;
    assign xIcapRdWrB        = 1'b0;
    assign xIcapData         = emit ? out_word : data_q;
    assign xBusy             = (state_q != ST_IDLE);
    assign xDone             = done_q;
    assign xError            = error_q;
    assign xErrorCode        = err_code_q;
    assign xWordCount        = word_cnt_q;

endmodule

// File: tb/tb_icap_stream_controller.sv
// tb_icap_stream_controller: randomized and directed checks of the ICAP
// stream controller against a transfer-level reference model.
module tb_icap_stream_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        avail_r = 1'b1;
    logic        avail_fix = 1'b1;
    logic        avail_rand = 1'b0;
    logic        avail;
    logic        prdone = 1'b0;
    logic        prerror = 1'b0;
    logic        csib;
    logic        rdwrb;
    logic [31:0] idata;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  ecode;
    logic [31:0] wcnt;

    assign avail = avail_rand ? avail_r : avail_fix;

    icap_stream_controller #(
        .BIT_SWAP       (1'b1),
        .TIMEOUT_CYCLES (16),
        .REQUIRE_PRDONE (1'b1)
    ) dut (
        .AxiBusClock       (clk),
        .xAxiBusReset_n    (rst_n),
        .xStart            (start),
        .xAbort            (abort),
        .xIcapS_AXI_tdata  (tdata),
        .xIcapS_AXI_tkeep  (tkeep),
        .xIcapS_AXI_tlast  (tlast),
        .xIcapS_AXI_tvalid (tvalid),
        .xIcapS_AXI_tready (tready),
        .xIcapAvail        (avail),
        .xIcapPrDone       (prdone),
        .xIcapPrError      (prerror),
        .xIcapCsib         (csib),
        .xIcapRdWrB        (rdwrb),
        .xIcapData         (idata),
        .xBusy             (busy),
        .xDone             (done),
        .xError            (err),
        .xErrorCode        (ecode),
        .xWordCount        (wcnt)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ICAP write log and I-stability monitor
    logic [31:0] wr_log [0:2047];
    int          wr_n = 0;
    int          stab_bad = 0;
    logic [31:0] prev_data = '0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!csib) begin
                if (wr_n < 2048) wr_log[wr_n] = idata;
                wr_n++;
            end else if (idata !== prev_data) begin
                stab_bad++;
            end
        end
        prev_data = idata;
    end

    // Random AVAIL with low runs capped well below the timeout
    initial begin
        int run;
        run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (run >= 6 || $urandom_range(0, 9) < 6) begin
                avail_r = 1'b1;
                run = 0;
            end else begin
                avail_r = 1'b0;
                run++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        return {{<<{w[31:24]}}, {<<{w[23:16]}}, {<<{w[15:8]}}, {<<{w[7:0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l);
        bit ok;
        ok = 0;
        tdata = d;
        tkeep = k;
        tlast = l;
        tvalid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (tready) ok = 1;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast = 1'b0;
        if (!ok) chk("beat_accept", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (wr_n < n && t < 300) begin
            tick();
            t++;
        end
        if (wr_n < n) chk("write_wait", wr_n, n);
    endtask

    task automatic chk_words(input int base, input logic [31:0] exp[$],
                             input int n);
        chk("n_writes", wr_n - base, n);
        chk("word_count", wcnt, n);
        for (int i = 0; i < n && i < exp.size(); i++) begin
            chk("icap_word", wr_log[base+i], exp[i]);
        end
    endtask

    int last_base;

    task automatic run_good(input int nb, input bit short_last,
                            input bit rand_av, input bit restart_mid,
                            input bit use_d0, input logic [63:0] d0);
        logic [31:0] exp[$];
        logic [63:0] d;
        logic [7:0]  k;
        bit          l;
        int          base;
        avail_rand = rand_av;
        avail_fix = 1'b1;
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
        chk("start_cnt_clr", wcnt, 0);
        base = wr_n;
        last_base = base;
        for (int b = 0; b < nb; b++) begin
            d = (b == 0 && use_d0) ? d0 : {$urandom, $urandom};
            l = (b == nb - 1);
            k = (l && short_last) ? 8'h0F : 8'hFF;
            exp.push_back(ref_swap(d[31:0]));
            if (k == 8'hFF) exp.push_back(ref_swap(d[63:32]));
            send_beat(d, k, l);
            if (b == 0 && restart_mid) pulse_start();
        end
        wait_writes(base + exp.size());
        prdone = 1'b1;
        tick();
        prdone = 1'b0;
        tick();
        avail_rand = 1'b0;
        chk("good_busy", busy, 0);
        chk("good_done", done, 1);
        chk("good_err", err, 0);
        chk("good_code", ecode, 0);
        chk_words(base, exp, exp.size());
    endtask

    task automatic run_badkeep(input int nb, input int k,
                               input logic [7:0] kb);
        logic [31:0] exp[$];
        logic [63:0] d;
        int          base;
        avail_rand = 1'b1;
        pulse_start();
        base = wr_n;
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            if (b < k) begin
                exp.push_back(ref_swap(d[31:0]));
                exp.push_back(ref_swap(d[63:32]));
            end
            send_beat(d, (b == k) ? kb : 8'hFF, b == nb - 1);
        end
        @(negedge clk);
        avail_rand = 1'b0;
        chk("tkeep_busy", busy, 0);
        chk("tkeep_err", err, 1);
        chk("tkeep_code", ecode, 3);
        chk("tkeep_done", done, 0);
        chk_words(base, exp, 2 * k);
    endtask

    task automatic run_err(input bit use_abort, input int trig, input int nb,
                           input bit rand_av);
        logic [31:0] exp[$];
        logic [63:0] beats[$];
        logic [63:0] d;
        int          base;
        avail_rand = rand_av;
        avail_fix = 1'b1;
        pulse_start();
        base = wr_n;
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            beats.push_back(d);
            exp.push_back(ref_swap(d[31:0]));
            exp.push_back(ref_swap(d[63:32]));
        end
        fork
            for (int b = 0; b < nb; b++) send_beat(beats[b], 8'hFF, b == nb - 1);
            begin
                int seen;
                seen = 0;
                for (int t = 0; t < 400 && seen < trig; t++) begin
                    @(negedge clk);
                    if (!csib) seen++;
                end
                @(posedge clk);
                #1;
                if (use_abort) abort = 1'b1;
                else prerror = 1'b1;
                tick();
                abort = 1'b0;
                prerror = 1'b0;
            end
        join
        @(negedge clk);
        avail_rand = 1'b0;
        chk("errx_busy", busy, 0);
        chk("errx_err", err, 1);
        chk("errx_code", ecode, use_abort ? 4 : 1);
        chk("errx_done", done, 0);
        chk_words(base, exp, trig);
    endtask

    initial begin
        logic [63:0] d;
        int          base;
        int          k;
        int          stall_bad;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_csib", csib, 1);
        chk("rst_data", idata, 0);
        chk("rst_rdwrb", rdwrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", {done, err, ecode}, 0);
        chk("rst_cnt", wcnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle_abort_err", err, 0);
        chk("idle_abort_busy", busy, 0);

        // known beat through the byte bit swap
        run_good(2, 0, 0, 0, 1, 64'h000000BB_AA995566);
        chk("swap_lo", wr_log[last_base], 32'h5599AA66);
        chk("swap_hi", wr_log[last_base+1], 32'h000000DD);
        chk("csib_low_cycles", wr_n - last_base, 4);

        // short final beat gives three words
        run_good(2, 1, 0, 0, 0, 64'h0);
        chk("short_words", wr_n - last_base, 3);

        // AVAIL low for 10 cycles before the high word
        avail_rand = 1'b0;
        avail_fix = 1'b1;
        pulse_start();
        base = wr_n;
        d = {$urandom, $urandom};
        stall_bad = 0;
        fork
            send_beat(d, 8'hFF, 1'b1);
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (!csib) break;
                end
                @(posedge clk);
                #1;
                avail_fix = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (!csib) stall_bad++;
                    if (idata !== ref_swap(d[31:0])) stall_bad++;
                end
                @(posedge clk);
                #1;
                avail_fix = 1'b1;
            end
        join
        wait_writes(base + 2);
        chk("stall_quiet", stall_bad, 0);
        chk("stall_hi_word", wr_log[base+1], ref_swap(d[63:32]));
        prdone = 1'b1;
        tick();
        prdone = 1'b0;
        tick();
        chk("stall_nwr", wr_n - base, 2);
        chk("stall_cnt", wcnt, 2);
        chk("stall_done", done, 1);

        // bad tkeep mid-stream goes to DRAIN
        run_badkeep(3, 1, 8'h03);

        // PRERROR after word 2 of a 5-beat stream
        run_err(0, 2, 5, 0);

        // abort mid-stream
        run_err(1, 3, 4, 0);

        // PRERROR beats PRDONE in the same cycle
        avail_fix = 1'b1;
        pulse_start();
        base = wr_n;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        wait_writes(base + 2);
        prdone = 1'b1;
        prerror = 1'b1;
        tick();
        prdone = 1'b0;
        prerror = 1'b0;
        tick();
        chk("both_err", err, 1);
        chk("both_code", ecode, 1);
        chk("both_done", done, 0);

        // PRDONE never comes: timeout after 16 waiting cycles
        pulse_start();
        base = wr_n;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        wait_writes(base + 2);
        k = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy) break;
            k++;
        end
        chk("tmo_cycles", k, 16);
        chk("tmo_err", err, 1);
        chk("tmo_code", ecode, 2);
        chk("tmo_done", done, 0);
        @(posedge clk);
        #1;

        // randomized transfers
        for (int it = 0; it < 14; it++) begin
            int kind;
            int nb;
            kind = $urandom_range(0, 2);
            nb = $urandom_range(2, 6);
            if (kind == 0) begin
                run_good(nb, $urandom_range(0, 1) == 1, 1,
                         $urandom_range(0, 1) == 1, 0, 64'h0);
            end else if (kind == 1) begin
                run_badkeep(nb + 1, $urandom_range(0, nb - 1),
                            8'($urandom_range(0, 254)));
            end else begin
                run_err($urandom_range(0, 1) == 1,
                        $urandom_range(1, 2 * nb - 1), nb, 1);
            end
        end

        // reset asserted mid-beat
        avail_rand = 1'b0;
        avail_fix = 1'b1;
        pulse_start();
        base = wr_n;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        wait_writes(base + 2);
        chk("pre_rst_cnt", wcnt, 2);
        avail_fix = 1'b0;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        tdata = {$urandom, $urandom};
        tkeep = 8'hFF;
        tvalid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csib", csib, 1);
        chk("mid_rst_tready", tready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", wcnt, 0);
        chk("mid_rst_status", {done, err, ecode}, 0);
        chk("mid_rst_data", idata, 0);
        tvalid = 1'b0;
        avail_fix = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_tready", tready, 0);
        chk("post_rst_busy", busy, 0);

        chk("i_stable", stab_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icap_stream_controller.md
Name: icap_stream_controller

Overview:
Sequences partial-reconfiguration bitstream delivery from the PCIe bridge's 64-bit AXI-Stream into the ICAPE3 primitive, all in the AxiBusClock domain.
- Splits each beat into two 32-bit ICAP words with optional per-byte bit swap.
- Honours ICAP AVAIL backpressure and monitors PRDONE/PRERROR with a timeout.
- Exposes start/abort control and sticky status for the MicroBlaze/DFX register bank.

Parameters:
BIT_SWAP, 1, 1 = reverse bit order within each byte before driving ICAP I.
TIMEOUT_CYCLES, 1048576, max cycles waiting on AVAIL or PRDONE before timeout error.
REQUIRE_PRDONE, 1, 1 = wait for PRDONE after the last word; 0 = done immediately after the last word.

Ports:
AxiBusClock  in  1  sole clock.
xAxiBusReset_n  in  1  reset, asynchronous, active-low.
xStart  in  1  one-cycle pulse; arms a transfer (ignored unless IDLE).
xAbort  in  1  one-cycle pulse; aborts the active transfer.
xIcapS_AXI_tdata  in  64  bitstream beat; low word is sent first.
xIcapS_AXI_tkeep  in  8  legal only 8'hFF, or 8'h0F on the tlast beat.
xIcapS_AXI_tlast  in  1  last beat of the bitstream.
xIcapS_AXI_tvalid  in  1  beat valid.
xIcapS_AXI_tready  out  1  beat accept.
xIcapAvail  in  1  ICAPE3 AVAIL.
xIcapPrDone  in  1  ICAPE3 PRDONE.
xIcapPrError  in  1  ICAPE3 PRERROR.
xIcapCsib  out  1  ICAPE3 CSIB, active-low write enable.
xIcapRdWrB  out  1  ICAPE3 RDWRB, constant 0 (write).
xIcapData  out  32  ICAPE3 I.
xBusy  out  1  state not IDLE.
xDone  out  1  sticky success flag; cleared by xStart.
xError  out  1  sticky error flag; cleared by xStart.
xErrorCode  out  3  0 none, 1 PRERROR, 2 timeout, 3 bad tkeep, 4 aborted.
xWordCount  out  32  ICAP words written in the current or last transfer.

Behaviour:
- Reset values:
  - tready = 0, xIcapCsib = 1, xIcapData = 0.
  - All status outputs = 0; state IDLE; holding buffer empty.
- States: IDLE, STREAM, WAIT_DONE, DRAIN.
- IDLE:
  - tready = 0, so beats are backpressured.
  - On xStart: clear xDone, xError, xErrorCode and xWordCount, then go to STREAM.
- STREAM:
  - tready = !bufValid, a registered term.
  - On handshake in cycle N, latch tdata, tkeep and tlast; bufValid = 1 from N+1.
  - Emit the low word in the first cycle with AVAIL = 1. In that cycle CSIB = 0, I = swap(tdata[31:0]), and xWordCount increments.
  - Emit the high word the same way in the next AVAIL = 1 cycle, only if tkeep[7:4] = 4'hF.
  - bufValid clears the cycle after the final word. Best-case throughput is one beat per 3 cycles (N+1 low, N+2 high, tready again at N+3).
  - AVAIL = 0 with a word pending: CSIB = 1, hold the word and I stable, and run the timeout counter. The counter resets on each emitted word.
  - tkeep not 8'hFF, and not (8'h0F with tlast): do not write that beat; error code 3.
  - After the final word of a tlast beat: go to WAIT_DONE if REQUIRE_PRDONE, otherwise IDLE with xDone = 1.
- WAIT_DONE:
  - CSIB = 1 and tready = 0.
  - PRDONE = 1: go to IDLE with xDone = 1.
  - Counter reaches TIMEOUT_CYCLES: error code 2.
- Error entry, in STREAM or WAIT_DONE:
  - Triggers: xIcapPrError = 1 (code 1), timeout (code 2), bad tkeep (code 3), xAbort (code 4).
  - Set xError and xErrorCode (first error wins) and force CSIB = 1 that cycle.
  - If tlast has already been accepted, go to IDLE; otherwise go to DRAIN.
- DRAIN:
  - tready = 1; discard beats with no ICAP writes.
  - Go to IDLE the cycle after a tlast handshake. This keeps the PCIe DMA from hanging.
- Simultaneous events:
  - PRERROR beats PRDONE in the same cycle.
  - xAbort in IDLE, and xStart while busy, are ignored.
- xIcapData changes only on emitted words.
- Reset mid-operation: immediately return to the reset values. An in-flight stream is not drained; the host must reset the DMA.

Decomposition:
- Package icap_stream_pkg: state encoding, the ERR_NONE / ERR_PRERROR / ERR_TIMEOUT / ERR_TKEEP / ERR_ABORT constants, and a byte bit-reverse function.
- One natural sub-module: icap_timeout_counter (load/clear/enable, with an expiry flag).

Test Plan:
1. Start, then two beats tkeep FF, AVAIL = 1, beat0 = 64'h000000BB_AA995566, BIT_SWAP = 1, PRDONE pulse after the last write -> I sequence 5599AA66, 000000DD, …; CSIB low 4 cycles; xWordCount = 4; xDone = 1.
2. AVAIL held low 10 cycles before the high word -> CSIB high and I stable for those 10 cycles, then the word is written once; count unaffected.
3. Final beat tkeep 0F with tlast, after 1 full beat -> exactly 3 words written; a tkeep 03 beat instead gives code 3 and DRAIN.
4. PRERROR after word 2 of a 5-beat stream -> xError = 1, code 1, further beats accepted with no CSIB activity until tlast, then IDLE.
5. TIMEOUT_CYCLES = 16, REQUIRE_PRDONE = 1, PRDONE never asserted -> code 2 at 16 cycles after the last word; xBusy drops the next cycle.
6. xAbort mid-stream -> code 4, DRAIN until tlast. Separately, reset asserted mid-beat -> CSIB = 1, tready = 0, status cleared asynchronously.
